// File: rtl/munoc_axi4_slave_memory_responder.sv
// AXI4 slave memory responder for MUNOC slave-NI ports: flop-based word memory,
// INCR/FIXED bursts, independent write (AW/W/B) and read (AR/R) state machines.
module munoc_axi4_slave_memory_responder #(
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int BW_AXI_SLAVE_TID = 4,
    parameter int DEPTH_LOG2       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BW_AXI_SLAVE_TID-1:0]   sx4awid,
    input  logic [BW_PLATFORM_ADDR-1:0]   sx4awaddr,
    input  logic [7:0]                    sx4awlen,
    input  logic [2:0]                    sx4awsize,
    input  logic [1:0]                    sx4awburst,
    input  logic                          sx4awvalid,
    output logic                          sx4awready,
    input  logic [BW_NODE_DATA-1:0]       sx4wdata,
    input  logic [BW_NODE_DATA/8-1:0]     sx4wstrb,
    input  logic                          sx4wlast,
    input  logic                          sx4wvalid,
    output logic                          sx4wready,
    output logic [BW_AXI_SLAVE_TID-1:0]   sx4bid,
    output logic [1:0]                    sx4bresp,
    output logic                          sx4bvalid,
    input  logic                          sx4bready,
    input  logic [BW_AXI_SLAVE_TID-1:0]   sx4arid,
    input  logic [BW_PLATFORM_ADDR-1:0]   sx4araddr,
    input  logic [7:0]                    sx4arlen,
    input  logic [2:0]                    sx4arsize,
    input  logic [1:0]                    sx4arburst,
    input  logic                          sx4arvalid,
    output logic                          sx4arready,
    output logic [BW_AXI_SLAVE_TID-1:0]   sx4rid,
    output logic [BW_NODE_DATA-1:0]       sx4rdata,
    output logic [1:0]                    sx4rresp,
    output logic                          sx4rlast,
    output logic                          sx4rvalid,
    input  logic                          sx4rready
);

    localparam int NBYTES   = BW_NODE_DATA / 8;
    localparam int BYTE_OFF = $clog2(NBYTES);
    localparam int DEPTH    = 1 << DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Burst-level faults outrank the per-beat address decode.
    function automatic logic [1:0] beat_resp(input logic [BW_PLATFORM_ADDR-1:0] addr,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
        if ((burst != BURST_FIXED && burst != BURST_INCR) || int'(size) > BYTE_OFF)
            return RESP_SLVERR;
        if ((addr >> (BYTE_OFF + DEPTH_LOG2)) != '0)
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [BW_PLATFORM_ADDR-1:0] next_addr(input logic [BW_PLATFORM_ADDR-1:0] addr,
                                                             input logic [2:0] size,
                                                             input logic [1:0] burst);
        if (burst == BURST_INCR)
            return addr + (BW_PLATFORM_ADDR'(1) << size);
        return addr;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [BW_PLATFORM_ADDR-1:0] addr);
        return addr[BYTE_OFF +: DEPTH_LOG2];
    endfunction

    logic [BW_NODE_DATA-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    w_state_t                      w_state, w_state_d;
    logic [BW_AXI_SLAVE_TID-1:0]   aw_id;
    logic [BW_PLATFORM_ADDR-1:0]   aw_addr;
    logic [7:0]                    aw_len, w_cnt;
    logic [2:0]                    aw_size;
    logic [1:0]                    aw_burst, w_resp, w_code, w_beat_resp;
    logic                          aw_hs, w_hs, b_hs, w_last_beat;

    assign aw_hs       = sx4awvalid & sx4awready;
    assign w_hs        = sx4wvalid & sx4wready;
    assign b_hs        = sx4bvalid & sx4bready;
    assign w_last_beat = (w_cnt == aw_len);
    assign w_code      = beat_resp(aw_addr, aw_size, aw_burst);
    assign w_beat_resp = ((sx4wlast != w_last_beat) && (w_code == RESP_OKAY)) ? RESP_SLVERR : w_code;

    // NOTE: next state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_state_d = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            sx4awready <= 1'b0;
            sx4wready  <= 1'b0;
            sx4bvalid  <= 1'b0;
            aw_id      <= '0;
            aw_addr    <= '0;
            aw_len     <= '0;
            aw_size    <= '0;
            aw_burst   <= '0;
            w_cnt      <= '0;
            w_resp     <= RESP_OKAY;
        end else begin
            w_state    <= w_state_d;
            sx4awready <= (w_state_d == W_IDLE);
            sx4wready  <= (w_state_d == W_DATA);
            sx4bvalid  <= (w_state_d == W_RESP);
            if (aw_hs) begin
                aw_id    <= sx4awid;
                aw_addr  <= sx4awaddr;
                aw_len   <= sx4awlen;
                aw_size  <= sx4awsize;
                aw_burst <= sx4awburst;
                w_cnt    <= '0;
                w_resp   <= RESP_OKAY;
            end
            if (w_hs) begin
                w_cnt   <= w_cnt + 8'd1;
                aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
                if (w_beat_resp > w_resp)
                    w_resp <= w_beat_resp;
            end
        end
    end

    assign sx4bid   = aw_id;
    assign sx4bresp = w_resp;

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_hs && w_code == RESP_OKAY) begin
            for (int i = 0; i < NBYTES; i++)
                if (sx4wstrb[i])
                    mem[word_idx(aw_addr)][8*i +: 8] <= sx4wdata[8*i +: 8];
        end
    end

    // ---------------- read path ----------------
    r_state_t                      r_state, r_state_d;
    logic [BW_AXI_SLAVE_TID-1:0]   ar_id;
    logic [BW_PLATFORM_ADDR-1:0]   ar_addr, ld_addr;
    logic [7:0]                    ar_len, r_cnt;
    logic [2:0]                    ar_size, ld_size;
    logic [1:0]                    ar_burst, ld_burst, ld_resp;
    logic [BW_NODE_DATA-1:0]       ld_data;
    logic                          ar_hs, r_hs, ld_last, ld_en, r_idle;

    assign ar_hs  = sx4arvalid & sx4arready;
    assign r_hs   = sx4rvalid & sx4rready;
    assign r_idle = (r_state == R_IDLE);

    // Beat 0 is loaded straight from the AR channel; later beats from the advanced address.
    assign ld_addr  = r_idle ? sx4araddr  : next_addr(ar_addr, ar_size, ar_burst);
    assign ld_size  = r_idle ? sx4arsize  : ar_size;
    assign ld_burst = r_idle ? sx4arburst : ar_burst;
    assign ld_last  = r_idle ? (sx4arlen == 8'd0) : ((r_cnt + 8'd1) == ar_len);
    assign ld_resp  = beat_resp(ld_addr, ld_size, ld_burst);
    assign ld_data  = (ld_resp == RESP_OKAY) ? mem[word_idx(ld_addr)] : '0;
    assign ld_en    = ar_hs | (r_hs & ~sx4rlast);

    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && sx4rlast) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            sx4arready <= 1'b0;
            sx4rvalid  <= 1'b0;
            sx4rdata   <= '0;
            sx4rresp   <= RESP_OKAY;
            sx4rlast   <= 1'b0;
            ar_id      <= '0;
            ar_addr    <= '0;
            ar_len     <= '0;
            ar_size    <= '0;
            ar_burst   <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= r_state_d;
            sx4arready <= (r_state_d == R_IDLE);
            sx4rvalid  <= (r_state_d == R_DATA);
            if (ar_hs) begin
                ar_id    <= sx4arid;
                ar_len   <= sx4arlen;
                ar_size  <= sx4arsize;
                ar_burst <= sx4arburst;
                r_cnt    <= '0;
            end else if (r_hs && !sx4rlast) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (ld_en) begin
                ar_addr  <= ld_addr;
                sx4rdata <= ld_data;
                sx4rresp <= ld_resp;
                sx4rlast <= ld_last;
            end
        end
    end

    assign sx4rid = ar_id;

endmodule

// File: tb/tb_munoc_axi4_slave_memory_responder.sv
// Directed self-checking bench for munoc_axi4_slave_memory_responder (default parameters).
module tb_munoc_axi4_slave_memory_responder;

    logic        clk, rst;
    logic [3:0]  sx4awid;
    logic [31:0] sx4awaddr;
    logic [7:0]  sx4awlen;
    logic [2:0]  sx4awsize;
    logic [1:0]  sx4awburst;
    logic        sx4awvalid, sx4awready;
    logic [31:0] sx4wdata;
    logic [3:0]  sx4wstrb;
    logic        sx4wlast, sx4wvalid, sx4wready;
    logic [3:0]  sx4bid;
    logic [1:0]  sx4bresp;
    logic        sx4bvalid, sx4bready;
    logic [3:0]  sx4arid;
    logic [31:0] sx4araddr;
    logic [7:0]  sx4arlen;
    logic [2:0]  sx4arsize;
    logic [1:0]  sx4arburst;
    logic        sx4arvalid, sx4arready;
    logic [3:0]  sx4rid;
    logic [31:0] sx4rdata;
    logic [1:0]  sx4rresp;
    logic        sx4rlast, sx4rvalid, sx4rready;

    munoc_axi4_slave_memory_responder dut (
        .clk(clk), .rst(rst),
        .sx4awid(sx4awid), .sx4awaddr(sx4awaddr), .sx4awlen(sx4awlen), .sx4awsize(sx4awsize),
        .sx4awburst(sx4awburst), .sx4awvalid(sx4awvalid), .sx4awready(sx4awready),
        .sx4wdata(sx4wdata), .sx4wstrb(sx4wstrb), .sx4wlast(sx4wlast), .sx4wvalid(sx4wvalid),
        .sx4wready(sx4wready),
        .sx4bid(sx4bid), .sx4bresp(sx4bresp), .sx4bvalid(sx4bvalid), .sx4bready(sx4bready),
        .sx4arid(sx4arid), .sx4araddr(sx4araddr), .sx4arlen(sx4arlen), .sx4arsize(sx4arsize),
        .sx4arburst(sx4arburst), .sx4arvalid(sx4arvalid), .sx4arready(sx4arready),
        .sx4rid(sx4rid), .sx4rdata(sx4rdata), .sx4rresp(sx4rresp), .sx4rlast(sx4rlast),
        .sx4rvalid(sx4rvalid), .sx4rready(sx4rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int to_cnt   = 0;

    logic [31:0] wd [4];
    logic [31:0] rd [4];
    logic [1:0]  rr [4];
    logic        rl [4];
    logic [3:0]  rids [4];
    logic        bv_now, rv_now, r_after;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    int          early_b, r_gap;

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        sx4awid = id; sx4awaddr = addr; sx4awlen = len; sx4awsize = size; sx4awburst = burst;
        sx4awvalid = 1'b1;
        for (int n = 0; sx4awready !== 1'b1; n++) begin
            if (n == 100) begin to_cnt++; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        sx4awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        sx4arid = id; sx4araddr = addr; sx4arlen = len; sx4arsize = size; sx4arburst = burst;
        sx4arvalid = 1'b1;
        for (int n = 0; sx4arready !== 1'b1; n++) begin
            if (n == 100) begin to_cnt++; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        sx4arvalid = 1'b0;
    endtask

    // Drives a whole write burst from wd[]; wlast is raised on beat last_beat only.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input int last_beat);
        early_b = 0;
        sx4bready = 1'b1;
        send_aw(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            sx4wdata = wd[b]; sx4wstrb = strb; sx4wlast = (b == last_beat); sx4wvalid = 1'b1;
            for (int n = 0; sx4wready !== 1'b1; n++) begin
                if (n == 100) begin to_cnt++; break; end
                @(posedge clk); #1;
            end
            if (sx4bvalid === 1'b1) early_b++;
            @(posedge clk); #1;
        end
        sx4wvalid = 1'b0; sx4wlast = 1'b0;
        bv_now = sx4bvalid; b_id = sx4bid; b_resp = sx4bresp;
        for (int n = 0; sx4bvalid !== 1'b1; n++) begin
            if (n == 100) begin to_cnt++; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        sx4rready = 1'b1;
        r_gap = 0;
        send_ar(id, addr, len, size, burst);
        rv_now = sx4rvalid;
        for (int b = 0; b <= int'(len); b++) begin
            for (int n = 0; sx4rvalid !== 1'b1; n++) begin
                if (n == 100) begin to_cnt++; break; end
                r_gap++;
                @(posedge clk); #1;
            end
            rd[b] = sx4rdata; rr[b] = sx4rresp; rl[b] = sx4rlast; rids[b] = sx4rid;
            @(posedge clk); #1;
        end
        r_after = sx4rvalid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sx4awvalid = 0; sx4wvalid = 0; sx4arvalid = 0; sx4wlast = 0; sx4bready = 1; sx4rready = 1;
        sx4awid = 0; sx4awaddr = 0; sx4awlen = 0; sx4awsize = 0; sx4awburst = 0;
        sx4wdata = 0; sx4wstrb = 0;
        sx4arid = 0; sx4araddr = 0; sx4arlen = 0; sx4arsize = 0; sx4arburst = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({sx4awready, sx4wready, sx4bvalid, sx4arready, sx4rvalid, sx4rlast} !== 6'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 000000", {sx4awready, sx4wready, sx4bvalid, sx4arready, sx4rvalid, sx4rlast}); end
        checks++; if ({sx4bid, sx4bresp, sx4rid, sx4rresp, sx4rdata} !== 44'h0) begin failures++; $display("FAIL reset_payload: got %h expected 0", {sx4bid, sx4bresp, sx4rid, sx4rresp, sx4rdata}); end
        rst = 1'b0;
        checks++; if (sx4awready !== 1'b0) begin failures++; $display("FAIL reset_release_awready: got %b expected 0", sx4awready); end
        @(posedge clk); #1;
        checks++; if ({sx4awready, sx4arready} !== 2'b11) begin failures++; $display("FAIL reset_ready_after_edge: got %b expected 11", {sx4awready, sx4arready}); end
    endtask

    task automatic test_incr_write();
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        do_write(4'h5, 32'h10, 8'd3, 3'd2, 2'd1, 4'hF, 3);
        checks++; if (early_b != 0) begin failures++; $display("FAIL incr_write_early_b: got %0d expected 0", early_b); end
        checks++; if (bv_now !== 1'b1) begin failures++; $display("FAIL incr_write_bvalid_latency: got %b expected 1", bv_now); end
        checks++; if (b_resp !== 2'd0) begin failures++; $display("FAIL incr_write_bresp: got %0d expected 0", b_resp); end
        checks++; if (b_id !== 4'h5) begin failures++; $display("FAIL incr_write_bid: got %h expected 5", b_id); end
    endtask

    task automatic test_incr_read();
        do_read(4'h9, 32'h10, 8'd3, 3'd2, 2'd1);
        checks++; if (rv_now !== 1'b1) begin failures++; $display("FAIL incr_read_rvalid_t1: got %b expected 1", rv_now); end
        checks++; if (r_gap != 0) begin failures++; $display("FAIL incr_read_gaps: got %0d expected 0", r_gap); end
        for (int b = 0; b < 4; b++) begin
            checks++; if (rd[b] !== 32'(b + 1)) begin failures++; $display("FAIL incr_read_data%0d: got %h expected %h", b, rd[b], 32'(b + 1)); end
            checks++; if ({rl[b], rr[b], rids[b]} !== {(b == 3), 2'd0, 4'h9}) begin failures++; $display("FAIL incr_read_ctrl%0d: got last=%b resp=%0d id=%h expected last=%b resp=0 id=9", b, rl[b], rr[b], rids[b], (b == 3)); end
        end
        checks++; if (r_after !== 1'b0) begin failures++; $display("FAIL incr_read_end: got rvalid=%b expected 0", r_after); end
    endtask

    task automatic test_strobe();
        wd[0] = 32'h11223344;
        do_write(4'h1, 32'h20, 8'd0, 3'd2, 2'd1, 4'hF, 0);
        wd[0] = 32'hAABBCCDD;
        do_write(4'h1, 32'h20, 8'd0, 3'd2, 2'd1, 4'h3, 0);
        do_read(4'h2, 32'h20, 8'd0, 3'd2, 2'd1);
        checks++; if (rd[0] !== 32'h1122CCDD) begin failures++; $display("FAIL strobe_merge: got %h expected 1122ccdd", rd[0]); end
    endtask

    task automatic test_fixed();
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        do_write(4'h3, 32'h24, 8'd2, 3'd2, 2'd0, 4'hF, 2);
        checks++; if (b_resp !== 2'd0) begin failures++; $display("FAIL fixed_write_bresp: got %0d expected 0", b_resp); end
        do_read(4'h3, 32'h24, 8'd1, 3'd2, 2'd0);
        checks++; if (rd[0] !== 32'hC || rd[1] !== 32'hC) begin failures++; $display("FAIL fixed_last_stored: got %h %h expected c c", rd[0], rd[1]); end
    endtask

    task automatic test_concurrent();
        sx4awid = 4'h1; sx4awaddr = 32'h30; sx4awlen = 0; sx4awsize = 2; sx4awburst = 1; sx4awvalid = 1;
        sx4arid = 4'h6; sx4araddr = 32'h10; sx4arlen = 0; sx4arsize = 2; sx4arburst = 1; sx4arvalid = 1;
        sx4rready = 1; sx4bready = 1;
        checks++; if ({sx4awready, sx4arready} !== 2'b11) begin failures++; $display("FAIL concurrent_pre_ready: got %b expected 11", {sx4awready, sx4arready}); end
        @(posedge clk); #1;
        sx4awvalid = 0; sx4arvalid = 0;
        checks++; if ({sx4awready, sx4arready, sx4wready, sx4rvalid, sx4rlast} !== 5'b00111) begin failures++; $display("FAIL concurrent_accept: got %b expected 00111", {sx4awready, sx4arready, sx4wready, sx4rvalid, sx4rlast}); end
        checks++; if (sx4rdata !== 32'd1 || sx4rid !== 4'h6) begin failures++; $display("FAIL concurrent_rbeat: got %h id %h expected 1 id 6", sx4rdata, sx4rid); end
        sx4wdata = 32'h55; sx4wstrb = 4'hF; sx4wlast = 1; sx4wvalid = 1;
        @(posedge clk); #1;
        sx4wvalid = 0; sx4wlast = 0;
        checks++; if ({sx4rvalid, sx4bvalid, sx4bid, sx4bresp} !== {1'b0, 1'b1, 4'h1, 2'd0}) begin failures++; $display("FAIL concurrent_b: got rvalid=%b bvalid=%b bid=%h bresp=%0d expected 0 1 1 0", sx4rvalid, sx4bvalid, sx4bid, sx4bresp); end
        @(posedge clk); #1;
        checks++; if ({sx4bvalid, sx4awready} !== 2'b01) begin failures++; $display("FAIL concurrent_b_done: got %b expected 01", {sx4bvalid, sx4awready}); end
    endtask

    task automatic test_same_word();
        send_aw(4'h2, 32'h30, 8'd0, 3'd2, 2'd1);
        sx4wdata = 32'h66; sx4wstrb = 4'hF; sx4wlast = 1; sx4wvalid = 1;
        sx4arid = 4'h4; sx4araddr = 32'h30; sx4arlen = 0; sx4arsize = 2; sx4arburst = 1; sx4arvalid = 1;
        checks++; if ({sx4wready, sx4arready} !== 2'b11) begin failures++; $display("FAIL same_word_pre_ready: got %b expected 11", {sx4wready, sx4arready}); end
        @(posedge clk); #1;
        sx4wvalid = 0; sx4wlast = 0; sx4arvalid = 0;
        checks++; if (sx4rvalid !== 1'b1 || sx4rdata !== 32'h55) begin failures++; $display("FAIL same_word_pre_write_data: got rvalid=%b data=%h expected 1 55", sx4rvalid, sx4rdata); end
        @(posedge clk); #1;
        do_read(4'h4, 32'h30, 8'd0, 3'd2, 2'd1);
        checks++; if (rd[0] !== 32'h66) begin failures++; $display("FAIL same_word_post_write: got %h expected 66", rd[0]); end
    endtask

    task automatic test_errors();
        wd[0] = 32'hDEAD0001; wd[1] = 32'hDEAD0002;
        do_write(4'h8, 32'h10, 8'd1, 3'd2, 2'd2, 4'hF, 1);
        checks++; if (b_resp !== 2'd2 || b_id !== 4'h8) begin failures++; $display("FAIL wrap_write_bresp: got %0d id %h expected 2 id 8", b_resp, b_id); end
        do_write(4'h8, 32'h14, 8'd0, 3'd3, 2'd1, 4'hF, 0);
        checks++; if (b_resp !== 2'd2) begin failures++; $display("FAIL size_write_bresp: got %0d expected 2", b_resp); end
        do_read(4'h0, 32'h10, 8'd1, 3'd2, 2'd1);
        checks++; if (rd[0] !== 32'd1 || rd[1] !== 32'd2) begin failures++; $display("FAIL error_write_unchanged: got %h %h expected 1 2", rd[0], rd[1]); end
        do_write(4'hA, 32'h400, 8'd0, 3'd2, 2'd1, 4'hF, 0);
        checks++; if (b_resp !== 2'd3) begin failures++; $display("FAIL decerr_write_bresp: got %0d expected 3", b_resp); end
        wd[0] = 32'h77;
        do_write(4'hA, 32'h3FC, 8'd0, 3'd2, 2'd1, 4'hF, 0);
        checks++; if (b_resp !== 2'd0) begin failures++; $display("FAIL top_word_write_bresp: got %0d expected 0", b_resp); end
        do_read(4'hB, 32'h3FC, 8'd0, 3'd2, 2'd1);
        checks++; if (rd[0] !== 32'h77 || rr[0] !== 2'd0) begin failures++; $display("FAIL top_word_read: got %h resp %0d expected 77 resp 0", rd[0], rr[0]); end
        do_read(4'hC, 32'h400, 8'd1, 3'd2, 2'd1);
        for (int b = 0; b < 2; b++) begin
            checks++; if ({rd[b], rr[b], rl[b]} !== {32'h0, 2'd3, (b == 1)}) begin failures++; $display("FAIL decerr_read_beat%0d: got data=%h resp=%0d last=%b expected 0 3 %b", b, rd[b], rr[b], rl[b], (b == 1)); end
        end
        do_read(4'hD, 32'h12, 8'd0, 3'd1, 2'd1);
        checks++; if (rd[0] !== 32'd1 || rr[0] !== 2'd0) begin failures++; $display("FAIL narrow_read: got %h resp %0d expected 1 resp 0", rd[0], rr[0]); end
        do_read(4'hD, 32'h10, 8'd0, 3'd3, 2'd1);
        checks++; if (rd[0] !== 32'h0 || rr[0] !== 2'd2) begin failures++; $display("FAIL oversize_read: got %h resp %0d expected 0 resp 2", rd[0], rr[0]); end
    endtask

    task automatic test_rready_stall();
        int idx;
        idx = 0;
        sx4rready = 1'b0;
        send_ar(4'h7, 32'h10, 8'd3, 3'd2, 2'd1);
        for (int c = 0; c < 40 && idx < 4; c++) begin
            sx4rready = c[0];
            if (sx4rvalid === 1'b1) begin
                checks++; if (sx4rdata !== 32'(idx + 1) || sx4rlast !== (idx == 3)) begin failures++; $display("FAIL stall_payload cycle %0d: got data=%h last=%b expected %h %b", c, sx4rdata, sx4rlast, 32'(idx + 1), (idx == 3)); end
                if (sx4rready) idx++;
            end
            @(posedge clk); #1;
        end
        sx4rready = 1'b1;
        checks++; if (idx != 4 || sx4rvalid !== 1'b0) begin failures++; $display("FAIL stall_complete: got beats=%0d rvalid=%b expected 4 0", idx, sx4rvalid); end
    endtask

    task automatic test_wlast_early();
        wd[0] = 32'h50; wd[1] = 32'h51; wd[2] = 32'h52; wd[3] = 32'h53;
        do_write(4'hE, 32'h50, 8'd3, 3'd2, 2'd1, 4'hF, 1);
        checks++; if (early_b != 0 || bv_now !== 1'b1) begin failures++; $display("FAIL wlast_early_beats: got early=%0d bvalid=%b expected 0 1", early_b, bv_now); end
        checks++; if (b_resp !== 2'd2 || b_id !== 4'hE) begin failures++; $display("FAIL wlast_early_bresp: got %0d id %h expected 2 id e", b_resp, b_id); end
    endtask

    task automatic test_reset_mid_burst();
        sx4rready = 1'b0;
        send_ar(4'h3, 32'h10, 8'd3, 3'd2, 2'd1);
        send_aw(4'h3, 32'h60, 8'd3, 3'd2, 2'd1);
        sx4wdata = 32'h99; sx4wstrb = 4'hF; sx4wlast = 0; sx4wvalid = 1;
        @(posedge clk); #1;
        sx4wvalid = 0;
        checks++; if ({sx4rvalid, sx4wready} !== 2'b11) begin failures++; $display("FAIL midrst_in_flight: got %b expected 11", {sx4rvalid, sx4wready}); end
        rst = 1'b1;
        #1;
        checks++; if ({sx4rvalid, sx4wready, sx4bvalid, sx4awready, sx4arready} !== 5'b0) begin failures++; $display("FAIL midrst_async_clear: got %b expected 00000", {sx4rvalid, sx4wready, sx4bvalid, sx4awready, sx4arready}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; sx4rready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({sx4awready, sx4arready} !== 2'b11) begin failures++; $display("FAIL midrst_ready_after: got %b expected 11", {sx4awready, sx4arready}); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({sx4bvalid, sx4rvalid} !== 2'b00) begin failures++; $display("FAIL midrst_no_response: got %b expected 00", {sx4bvalid, sx4rvalid}); end
        do_read(4'h1, 32'h10, 8'd0, 3'd2, 2'd1);
        checks++; if (rd[0] !== 32'd1) begin failures++; $display("FAIL midrst_memory_kept: got %h expected 1", rd[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr_write();
        test_incr_read();
        test_strobe();
        test_fixed();
        test_concurrent();
        test_same_word();
        test_errors();
        test_rready_stall();
        test_wlast_early();
        test_reset_mid_burst();
        checks++; if (to_cnt != 0) begin failures++; $display("FAIL handshake_timeouts: got %0d expected 0", to_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
